// File: rtl/mod_addsub_pipe_if.sv
// Streaming handshake bundle for the modular add/subtract pipeline.
// The master drives operands and out_ready; the slave (the pipeline) answers.
interface mod_addsub_pipe_if #(
  parameter int DATA_WIDTH = 18,
  parameter int LANES      = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          op_sub;
  logic [LANES*DATA_WIDTH-1:0]   a;
  logic [LANES*DATA_WIDTH-1:0]   b;
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*DATA_WIDTH-1:0]   result;
  logic [LANES-1:0]              range_err;

  modport master (
    output in_valid, op_sub, a, b, out_ready,
    input  in_ready, out_valid, result, range_err
  );

  modport slave (
    input  in_valid, op_sub, a, b, out_ready,
    output in_ready, out_valid, result, range_err
  );
endinterface

// File: rtl/mod_addsub_pipe.sv
// Two-stage, multi-lane modular adder/subtractor with valid/ready flow control
// and a saturating counter of output beats that carried out-of-range operands.
module mod_addsub_pipe #(
  parameter int DATA_WIDTH    = 18,
  parameter int MODULUS       = 177147,
  parameter int LANES         = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  mod_addsub_pipe_if.slave         bus,
  input  logic                     err_clr,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  if (MODULUS < 2 || longint'(MODULUS) >= (longint'(1) << DATA_WIDTH)) begin : g_bad_modulus
    $error("mod_addsub_pipe: MODULUS must satisfy 2 <= MODULUS < 2**DATA_WIDTH");
  end

  // Two guard bits: one for the carry of a+b, one for the sign of t or d.
  localparam int                XW    = DATA_WIDTH + 2;
  localparam logic [XW-1:0]     MOD_X = XW'(MODULUS);

  logic                   s1_valid;
  logic                   s1_adv;
  logic                   s2_adv;

  logic [XW-1:0]          lane_a;
  logic [XW-1:0]          lane_b;
  logic [XW-1:0]          lane_sum;
  logic [XW-1:0]          lane_diff;
  logic [XW-1:0]          pri_c [LANES];
  logic [XW-1:0]          alt_c [LANES];
  logic [LANES-1:0]       bad_c;

  logic [XW-1:0]          pri_q [LANES];
  logic [XW-1:0]          alt_q [LANES];
  logic [LANES-1:0]       bad_q;

  logic                        out_valid_q;
  logic [LANES*DATA_WIDTH-1:0] result_q;
  logic [LANES-1:0]            range_err_q;

  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.range_err = range_err_q;

  // The preferred candidate (t for add, d for sub) is used when non-negative;
  // otherwise the alternate (s for add, u for sub) is already in range.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    lane_a    = '0;
    lane_b    = '0;
    lane_sum  = '0;
    lane_diff = '0;
    bad_c     = '0;
    for (int i = 0; i < LANES; i++) begin
      pri_c[i] = '0;
      alt_c[i] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      lane_a    = XW'(bus.a[i*DATA_WIDTH +: DATA_WIDTH]);
      lane_b    = XW'(bus.b[i*DATA_WIDTH +: DATA_WIDTH]);
      lane_sum  = lane_a + lane_b;
      lane_diff = lane_a - lane_b;
      pri_c[i]  = bus.op_sub ? lane_diff : lane_sum - MOD_X;
      alt_c[i]  = bus.op_sub ? lane_diff + MOD_X : lane_sum;
      bad_c[i]  = (lane_a >= MOD_X) || (lane_b >= MOD_X);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
    end
  end

  // NOTE: stage-1 data registers are not reset; s1_valid alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (s1_adv && bus.in_valid) begin
      for (int i = 0; i < LANES; i++) begin
        pri_q[i] <= pri_c[i];
        alt_q[i] <= alt_c[i];
      end
      bad_q <= bad_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      range_err_q <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        for (int i = 0; i < LANES; i++) begin
          if (bad_q[i]) begin
            result_q[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
          end else if (pri_q[i][XW-1]) begin
            result_q[i*DATA_WIDTH +: DATA_WIDTH] <= alt_q[i][DATA_WIDTH-1:0];
          end else begin
            result_q[i*DATA_WIDTH +: DATA_WIDTH] <= pri_q[i][DATA_WIDTH-1:0];
          end
        end
        range_err_q <= bad_q;
      end
    end
  end

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (out_valid_q && bus.out_ready && (|range_err_q) && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/mod_addsub_pipe.md
MOD_ADDSUB_PIPE -- requirements
Module: mod_addsub_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 18, bit width of one residue lane.
REQ-002 Parameter MODULUS, default 177147, lane modulus M; 2 <= M < 2^DATA_WIDTH, with an elaboration-time error otherwise.
REQ-003 Parameter LANES, default 4, number of independent residue lanes per beat.
REQ-004 Parameter ERR_CNT_WIDTH, default 16, width of the range-error counter.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  block accepts the input beat this cycle.
REQ-009 op_sub  input  1  0 = modular add (a+b), 1 = modular subtract (a-b); sampled with the beat.
REQ-010 a  input  LANES*DATA_WIDTH  operand A; lane i is bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 b  input  LANES*DATA_WIDTH  operand B, same packing as a.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  downstream accepts the result beat.
REQ-014 result  output  LANES*DATA_WIDTH  reduced residues, same packing as a.
REQ-015 range_err  output  LANES  per-lane flag, aligned with result: an operand of that lane was >= M.
REQ-016 err_clr  input  1  clears err_count.
REQ-017 err_count  output  ERR_CNT_WIDTH  saturating count of accepted output beats with any range_err bit set.

Function
REQ-018 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-019 Two register stages: S1 (operand compute) and S2 (select/output); with no stall, a beat accepted in cycle n appears at the outputs with out_valid in cycle n+2.
REQ-020 S2 advances when !out_valid || out_ready; S1 advances when !s1_valid || S2 advances; in_ready equals the S1 advance condition, combinationally.
REQ-021 Under stall, result, range_err and out_valid hold stable until the output transfer; no beat is dropped, duplicated or reordered.
REQ-022 S1, add: register s = a+b (DATA_WIDTH+1 bits) and t = s-M (DATA_WIDTH+2 bits, signed), both computed in parallel.
REQ-023 S1, sub: register d = a-b (signed) and u = d+M, both computed in parallel.
REQ-024 S2 selects add -> t if t >= 0, else s; sub -> d if d >= 0, else u; the output is always in [0, M-1].
REQ-025 S1 registers a per-lane flag set when a_i >= M or b_i >= M; S2 forces that lane's result to 0 and sets range_err[i]; other lanes are unaffected.
REQ-026 err_count increments by 1 per output transfer carrying any range_err bit and saturates at all-ones.
REQ-027 err_clr sets err_count to 0 on the next edge and takes priority over a simultaneous increment.
REQ-028 Lanes share the handshake and op_sub; there is no cross-lane arithmetic.

Reset
REQ-029 When reset is high at a clock edge: s1_valid=0, out_valid=0, result=0, range_err=0, err_count=0; in-flight beats are discarded.
REQ-030 in_ready is 1 in the first cycle after reset deasserts; reset asserted mid-stream drops all beats accepted before it.
REQ-031 Data registers other than the outputs listed in REQ-029 need no reset.

Verification
REQ-032 Add wrap, M=177147: a=177146, b=1, op_sub=0, out_ready=1 -> result lane=0, range_err=0, exactly 2 cycles later.
REQ-033 Sub borrow: a=5, b=7, op_sub=1 -> 177145; a=7, b=5, op_sub=1 -> 2; back-to-back beats give in-order results in consecutive cycles.
REQ-034 Range error: lane 2 a=177147, other lanes valid -> lane 2 result=0, range_err=4'b0100, err_count 0->1; other lanes correct.
REQ-035 Backpressure: hold out_ready=0 and offer 3 beats -> 2 accepted, in_ready=0 on the third; release -> all 3 results emerge in order, none lost.
REQ-036 Reset mid-operation: 2 beats in flight, assert reset 1 cycle -> out_valid=0 next cycle, no stale beat later emitted, err_count=0.
REQ-037 Counter: force err_count to all-ones via errored beats -> one more errored beat keeps all-ones; err_clr with a simultaneous errored beat -> 0.
